// File: rtl/any1_rob_ctrl_if.sv
// Handshake bundle between decode/execute/commit and the ANY-1 reorder-buffer controller.
interface any1_rob_ctrl_if #(
  parameter int unsigned RIDW = 6
) ();
  logic            alloc_req_i;
  logic            alloc_ok_o;
  logic [RIDW-1:0] alloc_rid_o;
  logic            done_v_i;
  logic [RIDW-1:0] done_rid_i;
  logic            done_exc_i;
  logic            flush_i;
  logic [RIDW-1:0] flush_rid_i;
  logic            cmt_stall_i;
  logic            cmt_o;
  logic [RIDW-1:0] cmt_rid_o;
  logic            cmt_exc_o;
  logic [RIDW-1:0] count_o;
  logic            full_o;
  logic            empty_o;

  modport master (
    output alloc_req_i, done_v_i, done_rid_i, done_exc_i, flush_i, flush_rid_i, cmt_stall_i,
    input  alloc_ok_o, alloc_rid_o, cmt_o, cmt_rid_o, cmt_exc_o, count_o, full_o, empty_o
  );

  modport slave (
    input  alloc_req_i, done_v_i, done_rid_i, done_exc_i, flush_i, flush_rid_i, cmt_stall_i,
    output alloc_ok_o, alloc_rid_o, cmt_o, cmt_rid_o, cmt_exc_o, count_o, full_o, empty_o
  );
endinterface

// File: rtl/any1_rob_ctrl.sv
// ANY-1 reorder-buffer sequencing: hands out rids, tracks done/exception bits,
// retires in order one per cycle and discards younger entries on flush or exception.
module any1_rob_ctrl #(
  parameter int unsigned ROB_ENTRIES = 32,
  parameter int unsigned RIDW        = 6
) (
  input  logic           clk_i,
  input  logic           rst_i,
  any1_rob_ctrl_if.slave rob
);
  localparam int unsigned IDXW = $clog2(ROB_ENTRIES);

  logic [RIDW-1:0]        head_q, head_d, tail_q, tail_d;
  logic [ROB_ENTRIES-1:0] v_q, v_d, done_q, done_d, exc_q, exc_d;
  logic                   cmt_q, cmt_d, cmt_exc_q, cmt_exc_d;
  logic [RIDW-1:0]        cmt_rid_q, cmt_rid_d;

  logic [RIDW-1:0] count, done_off, flush_off;
  logic [IDXW-1:0] hidx, tidx, didx, ent_off;
  logic            full, can_cmt, exc_cmt, alloc_ok, done_in, flush_in, done_keep;

  // Occupancy and window tests are all offsets from head in rid space.
  assign count     = tail_q - head_q;
  assign full      = (count == RIDW'(ROB_ENTRIES));
  assign hidx      = head_q[IDXW-1:0];
  assign tidx      = tail_q[IDXW-1:0];
  assign didx      = rob.done_rid_i[IDXW-1:0];
  assign done_off  = rob.done_rid_i - head_q;
  assign flush_off = rob.flush_rid_i - head_q;
  assign done_in   = rob.done_v_i & (done_off < count);
  assign flush_in  = rob.flush_i & (flush_off < count);
  assign done_keep = done_in & ~(flush_in & (done_off > flush_off));

  assign can_cmt  = v_q[hidx] & done_q[hidx] & ~rob.cmt_stall_i;
  assign exc_cmt  = can_cmt & exc_q[hidx];
  assign alloc_ok = rob.alloc_req_i & ~full & ~rob.flush_i & ~exc_cmt & ~rst_i;

  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    v_d       = v_q;
    done_d    = done_q;
    exc_d     = exc_q;
    cmt_d     = 1'b0;
    cmt_rid_d = cmt_rid_q;
    cmt_exc_d = cmt_exc_q;
    ent_off   = '0;

    if (can_cmt) begin
      cmt_d     = 1'b1;
      cmt_rid_d = head_q;
      cmt_exc_d = exc_q[hidx];
      head_d    = head_q + RIDW'(1);
    end

    if (exc_cmt) begin
      // Faulting retirement empties the window; everything younger is squashed.
      v_d    = '0;
      tail_d = head_q + RIDW'(1);
    end else begin
      if (can_cmt) v_d[hidx] = 1'b0;
      if (flush_in) begin
        for (int i = 0; i < int'(ROB_ENTRIES); i++) begin
          ent_off = IDXW'(i) - hidx;
          if ((RIDW'(ent_off) > flush_off) && (RIDW'(ent_off) < count)) v_d[i] = 1'b0;
        end
        tail_d = rob.flush_rid_i + RIDW'(1);
      end else if (alloc_ok) begin
        v_d[tidx]    = 1'b1;
        done_d[tidx] = 1'b0;
        exc_d[tidx]  = 1'b0;
        tail_d       = tail_q + RIDW'(1);
      end
      if (done_keep) begin
        done_d[didx] = 1'b1;
        exc_d[didx]  = rob.done_exc_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q    <= '0;
      tail_q    <= '0;
      v_q       <= '0;
      done_q    <= '0;
      exc_q     <= '0;
      cmt_q     <= 1'b0;
      cmt_rid_q <= '0;
      cmt_exc_q <= 1'b0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      v_q       <= v_d;
      done_q    <= done_d;
      exc_q     <= exc_d;
      cmt_q     <= cmt_d;
      cmt_rid_q <= cmt_rid_d;
      cmt_exc_q <= cmt_exc_d;
    end
  end

  assign rob.alloc_ok_o  = alloc_ok;
  assign rob.alloc_rid_o = tail_q;
  assign rob.cmt_o       = cmt_q;
  assign rob.cmt_rid_o   = cmt_rid_q;
  assign rob.cmt_exc_o   = cmt_exc_q;
  assign rob.count_o     = count;
  assign rob.full_o      = full;
  assign rob.empty_o     = (head_q == tail_q);
endmodule

// File: tb/tb_any1_rob_ctrl.sv
// Directed, table-driven bench for any1_rob_ctrl plus hand sequences for fill, wrap and async reset.
module tb_any1_rob_ctrl;
  localparam int unsigned RIDW = 6;

  typedef struct {
    logic rst, a, dv;
    logic [RIDW-1:0] drid;
    logic dexc, fl;
    logic [RIDW-1:0] frid;
    logic st;
    logic ok;
    logic [RIDW-1:0] arid;
    logic cmt;
    logic [RIDW-1:0] crid;
    logic cexc;
    logic [RIDW-1:0] cnt;
    logic full, empty;
  } vec_t;

  logic clk, rst;
  int   n_cmp, n_bad;
  vec_t tv[$];

  any1_rob_ctrl_if #(.RIDW(RIDW)) rob_if ();

  any1_rob_ctrl #(.ROB_ENTRIES(32), .RIDW(RIDW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .rob   (rob_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic a, input logic dv, input int drid, input logic dexc,
                       input logic fl, input int frid, input logic st);
    rst                = r;
    rob_if.alloc_req_i = a;
    rob_if.done_v_i    = dv;
    rob_if.done_rid_i  = RIDW'(drid);
    rob_if.done_exc_i  = dexc;
    rob_if.flush_i     = fl;
    rob_if.flush_rid_i = RIDW'(frid);
    rob_if.cmt_stall_i = st;
  endtask

  function automatic vec_t mkv(input logic r, input logic a, input logic dv, input int drid,
                               input logic dexc, input logic fl, input int frid, input logic st,
                               input logic ok, input int arid, input logic cmt, input int crid,
                               input logic cexc, input int cnt, input logic full, input logic empty);
    vec_t t;
    t.rst = r; t.a = a; t.dv = dv; t.drid = RIDW'(drid); t.dexc = dexc;
    t.fl = fl; t.frid = RIDW'(frid); t.st = st;
    t.ok = ok; t.arid = RIDW'(arid); t.cmt = cmt; t.crid = RIDW'(crid); t.cexc = cexc;
    t.cnt = RIDW'(cnt); t.full = full; t.empty = empty;
    return t;
  endfunction

  task automatic reset_dut();
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bit hit;
    n_cmp = 0;
    n_bad = 0;

    // Reset state, with a pending request that must not be granted
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk); #2;
    chk("rst_alloc_ok", int'(rob_if.alloc_ok_o), 0);
    chk("rst_cmt", int'(rob_if.cmt_o), 0);
    chk("rst_cmt_rid", int'(rob_if.cmt_rid_o), 0);
    chk("rst_cmt_exc", int'(rob_if.cmt_exc_o), 0);
    chk("rst_count", int'(rob_if.count_o), 0);
    chk("rst_empty", int'(rob_if.empty_o), 1);
    chk("rst_full", int'(rob_if.full_o), 0);

    // Fill: 32 grants, then full and the 33rd request refused
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      drive(0, 1, 0, 0, 0, 0, 0, 0);
      #2;
      chk("fill_ok", int'(rob_if.alloc_ok_o), 1);
      chk("fill_rid", int'(rob_if.alloc_rid_o), i);
      chk("fill_count", int'(rob_if.count_o), i);
    end
    @(negedge clk); #2;
    chk("full_flag", int'(rob_if.full_o), 1);
    chk("full_count", int'(rob_if.count_o), 32);
    chk("full_ok", int'(rob_if.alloc_ok_o), 0);
    chk("full_empty", int'(rob_if.empty_o), 0);

    //          rst a dv drid x fl frid st | ok arid cmt crid cexc cnt full empty
    tv.push_back(mkv(1,1,0,0,0,0,0,0, 0,0,0,0,0,0,0,1));
    tv.push_back(mkv(0,1,0,0,0,0,0,0, 1,0,0,0,0,0,0,1));
    tv.push_back(mkv(0,1,0,0,0,0,0,0, 1,1,0,0,0,1,0,0));
    tv.push_back(mkv(0,1,0,0,0,0,0,0, 1,2,0,0,0,2,0,0));
    tv.push_back(mkv(0,0,1,2,0,0,0,0, 0,3,0,0,0,3,0,0));
    tv.push_back(mkv(0,0,1,1,0,0,0,0, 0,3,0,0,0,3,0,0));
    tv.push_back(mkv(0,0,1,0,0,0,0,0, 0,3,0,0,0,3,0,0));
    tv.push_back(mkv(0,0,0,0,0,0,0,0, 0,3,0,0,0,3,0,0));
    tv.push_back(mkv(0,0,0,0,0,0,0,0, 0,3,1,0,0,2,0,0));
    tv.push_back(mkv(0,0,0,0,0,0,0,0, 0,3,1,1,0,1,0,0));
    tv.push_back(mkv(0,0,0,0,0,0,0,0, 0,3,1,2,0,0,0,1));
    tv.push_back(mkv(0,0,0,0,0,0,0,0, 0,3,0,2,0,0,0,1));
    // Mispredict flush at rid 2 of 0..5
    tv.push_back(mkv(1,1,0,0,0,0,0,0, 0,0,0,0,0,0,0,1));
    for (int k = 0; k < 6; k++)
      tv.push_back(mkv(0,1,0,0,0,0,0,0, 1,k,0,0,0,k,0,(k == 0)));
    tv.push_back(mkv(0,1,0,0,0,1,2,0, 0,6,0,0,0,6,0,0));
    tv.push_back(mkv(0,0,1,4,0,0,0,0, 0,3,0,0,0,3,0,0));
    tv.push_back(mkv(0,1,0,0,0,0,0,0, 1,3,0,0,0,3,0,0));
    tv.push_back(mkv(0,0,0,0,0,1,10,0, 0,4,0,0,0,4,0,0));
    tv.push_back(mkv(0,0,0,0,0,0,0,0, 0,4,0,0,0,4,0,0));
    // Exception commit on rid 0 of 0..3
    tv.push_back(mkv(1,1,0,0,0,0,0,0, 0,0,0,0,0,0,0,1));
    for (int k = 0; k < 4; k++)
      tv.push_back(mkv(0,1,0,0,0,0,0,0, 1,k,0,0,0,k,0,(k == 0)));
    tv.push_back(mkv(0,0,1,0,1,0,0,0, 0,4,0,0,0,4,0,0));
    tv.push_back(mkv(0,1,1,1,0,0,0,0, 0,4,0,0,0,4,0,0));
    tv.push_back(mkv(0,0,0,0,0,0,0,0, 0,1,1,0,1,0,0,1));
    tv.push_back(mkv(0,1,0,0,0,0,0,0, 1,1,0,0,1,0,0,1));
    tv.push_back(mkv(0,0,0,0,0,0,0,0, 0,2,0,0,1,1,0,0));
    // Head completes, then three stalled commit edges
    tv.push_back(mkv(0,0,1,1,0,0,0,1, 0,2,0,0,1,1,0,0));
    for (int k = 0; k < 3; k++)
      tv.push_back(mkv(0,0,0,0,0,0,0,1, 0,2,0,0,1,1,0,0));
    tv.push_back(mkv(0,0,0,0,0,0,0,0, 0,2,0,0,1,1,0,0));
    tv.push_back(mkv(0,0,0,0,0,0,0,0, 0,2,1,1,0,0,0,1));
    tv.push_back(mkv(0,0,0,0,0,0,0,0, 0,2,0,1,0,0,0,1));

    foreach (tv[n]) begin
      @(negedge clk);
      drive(tv[n].rst, tv[n].a, tv[n].dv, int'(tv[n].drid), tv[n].dexc,
            tv[n].fl, int'(tv[n].frid), tv[n].st);
      #2;
      chk($sformatf("v%0d_alloc_ok", n), int'(rob_if.alloc_ok_o), int'(tv[n].ok));
      chk($sformatf("v%0d_alloc_rid", n), int'(rob_if.alloc_rid_o), int'(tv[n].arid));
      chk($sformatf("v%0d_cmt", n), int'(rob_if.cmt_o), int'(tv[n].cmt));
      chk($sformatf("v%0d_cmt_rid", n), int'(rob_if.cmt_rid_o), int'(tv[n].crid));
      chk($sformatf("v%0d_cmt_exc", n), int'(rob_if.cmt_exc_o), int'(tv[n].cexc));
      chk($sformatf("v%0d_count", n), int'(rob_if.count_o), int'(tv[n].cnt));
      chk($sformatf("v%0d_full", n), int'(rob_if.full_o), int'(tv[n].full));
      chk($sformatf("v%0d_empty", n), int'(rob_if.empty_o), int'(tv[n].empty));
    end

    // Wrap-around: 40 allocations each completed one cycle later, then drain
    reset_dut();
    for (int c = 0; c < 43; c++) begin
      int exp_cnt;
      @(negedge clk);
      drive(0, (c < 40), (c >= 1 && c <= 40), c - 1, 0, 0, 0, 0);
      #2;
      exp_cnt = ((c < 40) ? c : 40) - ((c > 2) ? c - 2 : 0);
      if (c < 40) begin
        chk("wrap_ok", int'(rob_if.alloc_ok_o), 1);
        chk("wrap_rid", int'(rob_if.alloc_rid_o), c);
      end
      chk("wrap_count", int'(rob_if.count_o), exp_cnt);
      chk("wrap_cmt", int'(rob_if.cmt_o), (c >= 3) ? 1 : 0);
      if (c >= 3) chk("wrap_cmt_rid", int'(rob_if.cmt_rid_o), c - 3);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("wrap_empty", int'(rob_if.empty_o), 1);
    chk("wrap_end_count", int'(rob_if.count_o), 0);
    chk("wrap_end_rid", int'(rob_if.alloc_rid_o), 40);

    // Async reset while a retirement strobe is showing and entries remain
    reset_dut();
    @(negedge clk); drive(0, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk); drive(0, 1, 1, 0, 0, 0, 0, 0);
    @(negedge clk); drive(0, 1, 1, 1, 0, 0, 0, 0);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0);
    hit = 1'b0;
    for (int k = 0; k < 8 && !hit; k++) begin
      @(negedge clk); #2;
      if (rob_if.cmt_o && rob_if.cmt_rid_o == RIDW'(1)) hit = 1'b1;
    end
    chk("arst_setup_seen", int'(hit), 1);
    if (hit) begin
      chk("arst_pre_count", int'(rob_if.count_o), 1);
      rob_if.alloc_req_i = 1'b1;
      rst = 1'b1;
      #1;
      chk("arst_cmt", int'(rob_if.cmt_o), 0);
      chk("arst_cmt_rid", int'(rob_if.cmt_rid_o), 0);
      chk("arst_count", int'(rob_if.count_o), 0);
      chk("arst_empty", int'(rob_if.empty_o), 1);
      chk("arst_alloc_ok", int'(rob_if.alloc_ok_o), 0);
      chk("arst_alloc_rid", int'(rob_if.alloc_rid_o), 0);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
